// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU mode encodings and add/sub FSM state type
package alu_pkg;
  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_ADC = 2'b10;
  localparam logic [1:0] MODE_SBC = 2'b11;
  typedef enum logic [1:0] {
    ADD = MODE_ADD,
    SUB = MODE_SUB,
    ADC = MODE_ADC,
    SBC = MODE_SBC
  } alu_mode_e;
  typedef enum logic [1:0] {IDLE, CALC, DONE} addsub_state_e;
endpackage

// File: rtl/alu_chunk_adder.sv
// alu_chunk_adder: combinational CHUNK-bit full adder slice with carry into its MSB
module alu_chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  // carry into the MSB recovered from the MSB sum bit, valid for any CHUNK >= 1
  assign cmsb = sum[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];
endmodule

// File: rtl/alu_addsub_mc.sv
// alu_addsub_mc: multi-cycle chunked add/sub with carry, saturation and NZCV flags
module alu_addsub_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic [1:0]       mode,
  input  logic             carry_in,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             carry,
  output logic             ovf,
  output logic             zero,
  output logic             neg,
  output logic             busy
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  addsub_state_e state_q;
  alu_mode_e m;
  logic [WIDTH-1:0] a_q, b_q, dout_q, res_d, fin_d;
  logic [IW-1:0] idx_q;
  logic rc_q, sat_q, sgn_q, c_q, v_q, z_q, n_q;
  logic [CHUNK-1:0] sum;
  logic cout, cmsb, last;
  assign m = alu_mode_e'(mode);
  assign last = idx_q == IW'(NCHUNK - 1);
  alu_chunk_adder #(.CHUNK(CHUNK)) u_add (
    .a(a_q[CHUNK-1:0]), .b(b_q[CHUNK-1:0]), .cin(rc_q),
    .sum(sum), .cout(cout), .cmsb(cmsb)
  );
  always_comb begin
    res_d = dout_q;
    res_d[idx_q*CHUNK +: CHUNK] = sum;
    fin_d = (sat_q && (cmsb ^ cout)) ? {sgn_q, {(WIDTH-1){~sgn_q}}} : res_d;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      idx_q   <= '0;
      rc_q    <= 1'b0;
      sat_q   <= 1'b0;
      sgn_q   <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q     <= operand1;
          b_q     <= (m == SUB || m == SBC) ? ~operand2 : operand2;
          rc_q    <= (m == ADD) ? 1'b0 : (m == SUB) ? 1'b1 : carry_in;
          sat_q   <= sat_en;
          sgn_q   <= operand1[WIDTH-1];
          idx_q   <= '0;
          state_q <= CALC;
        end
        CALC: begin
          a_q    <= a_q >> CHUNK;
          b_q    <= b_q >> CHUNK;
          rc_q   <= cout;
          idx_q  <= idx_q + 1'b1;
          dout_q <= last ? fin_d : res_d;
          if (last) begin
            c_q     <= cout;
            v_q     <= cmsb ^ cout;
            z_q     <= fin_d == '0;
            n_q     <= fin_d[WIDTH-1];
            state_q <= DONE;
          end
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready  = state_q == IDLE;
  assign busy      = state_q == CALC;
  assign out_valid = state_q == DONE;
  assign dout      = dout_q;
  assign carry     = c_q;
  assign ovf       = v_q;
  assign zero      = z_q;
  assign neg       = n_q;
endmodule
